// File: rtl/systolic_pq_cell.sv
// One storage cell of a systolic priority queue plus its three-entry sorter.
// Define SYSTOLIC_PQ_OPERR_EN to add the sticky op_err spacing-violation flag.

module systolic_pq_sort3 #(
  parameter int KW = 9,
  parameter int W  = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] lo,
  output logic [W-1:0] mid,
  output logic [W-1:0] hi
);
  logic [W-1:0] s0_lo;
  logic [W-1:0] s0_hi;
  logic [W-1:0] s1_lo;

  // Three compare-exchange stages; only the top KW bits act as the key.
  always_comb begin
    if (a[W-1 -: KW] > b[W-1 -: KW]) begin
      s0_lo = b;
      s0_hi = a;
    end else begin
      s0_lo = a;
      s0_hi = b;
    end
    if (s0_hi[W-1 -: KW] > c[W-1 -: KW]) begin
      hi    = s0_hi;
      s1_lo = c;
    end else begin
      hi    = c;
      s1_lo = s0_hi;
    end
    if (s0_lo[W-1 -: KW] > s1_lo[W-1 -: KW]) begin
      lo  = s1_lo;
      mid = s0_lo;
    end else begin
      lo  = s0_lo;
      mid = s1_lo;
    end
  end
endmodule

module systolic_pq_cell #(
  parameter int KW = 8,
  parameter int VW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         op_in,
  input  logic [KW+VW-1:0]   din,
  input  logic [KW+VW-1:0]   rhead,
  input  logic               rhead_vld,
  output logic [KW+VW-1:0]   head_out,
  output logic               head_vld,
  output logic [1:0]         op_out,
  output logic [KW+VW-1:0]   dout,
  output logic               full
`ifdef SYSTOLIC_PQ_OPERR_EN
  ,
  output logic               op_err
`endif
);
  localparam int W  = KW + VW;
  localparam int EW = W + 1;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_EXT = 2'b10;

  logic [W-1:0] l_q, h_q, l_n, h_n;
  logic         vl_q, vh_q, vl_n, vh_n;
  logic [1:0]   op_q, op_n;
  logic [W-1:0] dout_q, dout_n;

  // Extended entries carry ~valid as the key MSB so empty slots sort as +infinity.
  logic [EW-1:0] l_x, h_x, d_x, r_x;
  logic [EW-1:0] s_min, s_med, s_max;
  logic [EW-1:0] e_lo, e_hi;

  assign l_x = {~vl_q, l_q};
  assign h_x = {~vh_q, h_q};
  assign d_x = {1'b0, din};
  assign r_x = {~rhead_vld, rhead};

  systolic_pq_sort3 #(
    .KW(KW + 1),
    .W (EW)
  ) u_sort3 (
    .a  (l_x),
    .b  (h_x),
    .c  (d_x),
    .lo (s_min),
    .mid(s_med),
    .hi (s_max)
  );

  always_comb begin
    if (h_x[EW-1 -: KW+1] <= r_x[EW-1 -: KW+1]) begin
      e_lo = h_x;
      e_hi = r_x;
    end else begin
      e_lo = r_x;
      e_hi = h_x;
    end
  end

  // Reserved op 2'b11 falls through to the hold/NOP default.
  always_comb begin
    l_n    = l_q;
    h_n    = h_q;
    vl_n   = vl_q;
    vh_n   = vh_q;
    op_n   = OP_NOP;
    dout_n = '0;
    case (op_in)
      OP_INS: begin
        l_n  = s_min[W-1:0];
        vl_n = ~s_min[EW-1];
        h_n  = s_med[W-1:0];
        vh_n = ~s_med[EW-1];
        if (!s_max[EW-1]) begin
          op_n   = OP_INS;
          dout_n = s_max[W-1:0];
        end
      end
      OP_EXT: begin
        if (vl_q) begin
          l_n  = e_lo[W-1:0];
          vl_n = ~e_lo[EW-1];
          h_n  = e_hi[W-1:0];
          vh_n = ~e_hi[EW-1];
          op_n = OP_EXT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q    <= '0;
      h_q    <= '0;
      vl_q   <= 1'b0;
      vh_q   <= 1'b0;
      op_q   <= OP_NOP;
      dout_q <= '0;
    end else begin
      l_q    <= l_n;
      h_q    <= h_n;
      vl_q   <= vl_n;
      vh_q   <= vh_n;
      op_q   <= op_n;
      dout_q <= dout_n;
    end
  end

  assign head_out = l_q;
  assign head_vld = vl_q;
  assign full     = vl_q & vh_q;
  assign op_out   = op_q;
  assign dout     = dout_q;

`ifdef SYSTOLIC_PQ_OPERR_EN
  logic act_q, err_q;
  logic act;

  assign act = (op_in == OP_INS) || (op_in == OP_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      act_q <= act;
      err_q <= err_q | (act & act_q);
    end
  end

  assign op_err = err_q;
`endif
endmodule
